// File: rtl/spu_io_pkg.sv
// Shared types and constants for the SPU host I/O bridge.
package spu_io_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Index width for a byte counter over n bytes; at least one bit so a
  // single-byte store still has a legal index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spu_byte_shreg.sv
// Byte-addressed register: single-byte indexed writes, plus a parallel
// whole-word load used when a complete word arrives at once.
module spu_byte_shreg
  import spu_io_pkg::*;
#(
  parameter int N_BYTES = 2,
  parameter int IDX_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [IDX_W-1:0]          idx,
  input  logic [BYTE_W-1:0]         din,
  input  logic                      ld,
  input  logic [N_BYTES*BYTE_W-1:0] ld_data,
  output logic [N_BYTES*BYTE_W-1:0] dout
);

  logic [BYTE_W-1:0] bytes_reg [N_BYTES];

  generate
    for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_byte
      // Each byte lane: cleared on reset, whole-word load wins over indexed write.
      always_ff @(posedge clk) begin
        if (rst) begin
          bytes_reg[gi] <= '0;
        end else if (ld) begin
          bytes_reg[gi] <= ld_data[gi*BYTE_W +: BYTE_W];
        end else if (we && (idx == IDX_W'(gi))) begin
          bytes_reg[gi] <= din;
        end
      end
      assign dout[gi*BYTE_W +: BYTE_W] = bytes_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/spu_io_bridge.sv
// Byte-serial host bridge: gathers operand bytes, hands the operand vector
// to the core, captures its result and streams it back byte by byte.
module spu_io_bridge
  import spu_io_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_OPS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_byte,
  input  logic                    in_stb,
  output logic                    in_rdy,
  output logic [N_OPS*DATA_W-1:0] ops_data,
  output logic                    ops_valid,
  input  logic                    ops_ready,
  input  logic [DATA_W-1:0]       res_data,
  input  logic                    res_valid,
  output logic                    res_ready,
  output logic [7:0]              out_byte,
  output logic                    out_stb,
  input  logic                    out_ack,
  output logic                    busy,
  output logic                    err
);

  localparam int IN_BYTES  = N_OPS * DATA_W / BYTE_W;
  localparam int OUT_BYTES = DATA_W / BYTE_W;
  localparam int IN_W      = idx_width(IN_BYTES);
  localparam int OUT_W     = idx_width(OUT_BYTES);
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_BYTES - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_BYTES - 1);

  state_t             state_reg;
  logic [IN_W-1:0]    in_cnt_reg;
  logic [OUT_W-1:0]   out_cnt_reg;
  logic               err_reg;
  logic [DATA_W-1:0]  res_word;

  logic in_fire;
  logic res_fire;
  logic out_fire;

  // Handshake strobes are pure state decodes so no input reaches an output.
  assign in_rdy    = (state_reg == ST_LOAD);
  assign ops_valid = (state_reg == ST_ISSUE);
  assign res_ready = (state_reg == ST_WAIT);
  assign out_stb   = (state_reg == ST_DRAIN);
  assign busy      = (state_reg != ST_LOAD);
  assign err       = err_reg;

  assign in_fire  = in_stb    && (state_reg == ST_LOAD);
  assign res_fire = res_valid && (state_reg == ST_WAIT);
  assign out_fire = out_ack   && (state_reg == ST_DRAIN);

  // Result is sent least-significant byte first.
  assign out_byte = res_word[out_cnt_reg*BYTE_W +: BYTE_W];

  // Transaction sequencer with input and output byte counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_LOAD;
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        ST_LOAD: begin
          if (in_fire) begin
            if (in_cnt_reg == IN_LAST) begin
              in_cnt_reg <= '0;
              state_reg  <= ST_ISSUE;
            end else begin
              in_cnt_reg <= in_cnt_reg + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (ops_ready) state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (res_fire) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (out_cnt_reg == OUT_LAST) begin
              out_cnt_reg <= '0;
              in_cnt_reg  <= '0;
              state_reg   <= ST_LOAD;
            end else begin
              out_cnt_reg <= out_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  // Sticky error: a byte offered while not ready, or an ack with nothing shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if ((in_stb && !in_fire) || (out_ack && !out_fire)) begin
      err_reg <= 1'b1;
    end
  end

  spu_byte_shreg #(
    .N_BYTES (IN_BYTES),
    .IDX_W   (IN_W)
  ) u_ops_store (
    .clk     (clk),
    .rst     (rst),
    .we      (in_fire),
    .idx     (in_cnt_reg),
    .din     (in_byte),
    .ld      (1'b0),
    .ld_data ('0),
    .dout    (ops_data)
  );

  spu_byte_shreg #(
    .N_BYTES (OUT_BYTES),
    .IDX_W   (OUT_W)
  ) u_res_store (
    .clk     (clk),
    .rst     (rst),
    .we      (1'b0),
    .idx     ('0),
    .din     ('0),
    .ld      (res_fire),
    .ld_data (res_data),
    .dout    (res_word)
  );

endmodule
